// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED SPI byte sequencer: state encoding
// and the SSD1306-style power-on command list (128x64 panel, charge pump on).
package oled_pkg;

    localparam int OLED_INIT_LEN = 25;

    localparam logic [7:0] OLED_INIT_ROM [OLED_INIT_LEN] = '{
        8'hAE,                          // display off while configuring
        8'hD5, 8'h80,
        8'hA8, 8'h3F,
        8'hD3, 8'h00,
        8'h40,
        8'h8D, 8'h14,
        8'h20, 8'h00,
        8'hA1,
        8'hC8,
        8'hDA, 8'h12,
        8'h81, 8'hCF,
        8'hD9, 8'hF1,
        8'hDB, 8'h40,
        8'hA4,
        8'hA6,
        8'hAF
    };

    typedef enum logic [3:0] {
        S_PAN_RST,
        S_WAKE,
        S_CMD_LD,
        S_CMD_TX,
        S_CMD_WT,
        S_READY,
        S_FB_RD,
        S_FB_CAP,
        S_FB_TX,
        S_FB_WT
    } seq_state_t;

endpackage

// File: rtl/oled_delay_cnt.sv
// Loadable down-counter with zero flag; load wins over count, counting stops at zero.
// Latency: o_zero reflects the registered count, so a load of N gives N+1 cycles to zero-exit.
module oled_delay_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_count,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    assign o_zero = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_count && !o_zero) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/oled_spi_sequencer.sv
// Panel reset/wake, init command list, then one framebuffer frame per request into the SPI master.
// One byte outstanding: tx_valid held until tx_ready, next byte only after the master's rx_valid.
module oled_spi_sequencer
    import oled_pkg::*;
#(
    parameter int RST_CYCLES  = 1000,
    parameter int WAKE_CYCLES = 100000,
    parameter int FRAME_BYTES = 1024,
    parameter int ADDR_W      = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    output logic              init_done,
    output logic              busy,
    output logic              frame_done,
    output logic              fb_rd,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [7:0]        fb_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [7:0]        tx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              oled_dc,
    output logic              oled_rst_n
);

    localparam int CNT_MAX = (RST_CYCLES > WAKE_CYCLES) ? RST_CYCLES : WAKE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(OLED_INIT_LEN);

    localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LOAD = (WAKE_CYCLES > 0) ? CNT_W'(WAKE_CYCLES - 1) : '0;

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [ADDR_W-1:0] r_fb_addr;
    logic [7:0]        r_tx_data;
    logic              r_tx_valid;
    logic              r_oled_dc;
    logic              r_oled_rst_n;
    logic              r_init_done;
    logic              r_frame_done;

    logic              w_tx_fire;
    logic              w_idx_last;
    logic              w_addr_last;
    logic              w_cnt_load;
    logic [CNT_W-1:0]  w_cnt_val;
    logic              w_cnt_en;
    logic              w_cnt_zero;

    assign w_tx_fire   = r_tx_valid && tx_ready;
    assign w_idx_last  = (r_idx == IDX_W'(OLED_INIT_LEN - 1));
    assign w_addr_last = (r_fb_addr == ADDR_W'(FRAME_BYTES - 1));

    oled_delay_cnt #(
        .W (CNT_W)
    ) u_delay (
        .clk        (clk),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_count    (w_cnt_en),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_PAN_RST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_PAN_RST: if (w_cnt_zero) w_state_nxt = S_WAKE;
            S_WAKE:    if (w_cnt_zero) w_state_nxt = S_CMD_LD;
            S_CMD_LD:  w_state_nxt = S_CMD_TX;
            S_CMD_TX:  if (w_tx_fire) w_state_nxt = S_CMD_WT;
            S_CMD_WT:  if (rx_valid) w_state_nxt = w_idx_last ? S_READY : S_CMD_LD;
            // a request coinciding with the frame_done pulse is dropped, not deferred
            S_READY:   if (frame_start && !r_frame_done) w_state_nxt = S_FB_RD;
            S_FB_RD:   w_state_nxt = S_FB_CAP;
            S_FB_CAP:  w_state_nxt = S_FB_TX;
            S_FB_TX:   if (w_tx_fire) w_state_nxt = S_FB_WT;
            S_FB_WT:   if (rx_valid) w_state_nxt = w_addr_last ? S_READY : S_FB_RD;
            default:   w_state_nxt = S_PAN_RST;
        endcase
    end

    // Counter reloads on every state entry; only the two timed states use the value.
    always_comb begin
        w_cnt_load = rst || (w_state_nxt != r_state);
        w_cnt_val  = '0;
        if (rst || w_state_nxt == S_PAN_RST) begin
            w_cnt_val = RST_LOAD;
        end else if (w_state_nxt == S_WAKE) begin
            w_cnt_val = WAKE_LOAD;
        end
        w_cnt_en = (r_state == S_PAN_RST) || (r_state == S_WAKE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx        <= '0;
            r_fb_addr    <= '0;
            r_tx_data    <= '0;
            r_tx_valid   <= 1'b0;
            r_oled_dc    <= 1'b0;
            r_oled_rst_n <= 1'b0;
            r_init_done  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_oled_rst_n <= (w_state_nxt != S_PAN_RST);
            r_frame_done <= 1'b0;
            case (r_state)
                S_CMD_LD: begin
                    r_tx_data  <= OLED_INIT_ROM[r_idx];
                    r_oled_dc  <= 1'b0;
                    r_tx_valid <= 1'b1;
                end
                S_CMD_TX, S_FB_TX: begin
                    if (w_tx_fire) r_tx_valid <= 1'b0;
                end
                S_CMD_WT: begin
                    if (rx_valid) begin
                        if (w_idx_last) r_init_done <= 1'b1;
                        else            r_idx       <= r_idx + 1'b1;
                    end
                end
                S_READY: begin
                    if (w_state_nxt == S_FB_RD) r_fb_addr <= '0;
                end
                S_FB_CAP: begin
                    r_tx_data  <= fb_data;
                    r_oled_dc  <= 1'b1;
                    r_tx_valid <= 1'b1;
                end
                S_FB_WT: begin
                    if (rx_valid) begin
                        if (w_addr_last) r_frame_done <= 1'b1;
                        else             r_fb_addr    <= r_fb_addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign init_done  = r_init_done;
    assign busy       = (r_state != S_READY);
    assign frame_done = r_frame_done;
    assign fb_rd      = (r_state == S_FB_RD);
    assign fb_addr    = r_fb_addr;
    assign tx_valid   = r_tx_valid;
    assign tx_data    = r_tx_data;
    assign rx_ready   = 1'b1;
    assign oled_dc    = r_oled_dc;
    assign oled_rst_n = r_oled_rst_n;

endmodule

// File: tb/tb_oled_spi_sequencer.sv
// Directed bench: small RST/WAKE/FRAME parameters, hand-written init list and frame contents,
// SPI master modelled inline (random accept delay, completion 16 cycles after accept).
module tb_oled_spi_sequencer;

    localparam int RST_C  = 4;
    localparam int WAKE_C = 8;
    localparam int FB_N   = 4;
    localparam int AW     = 4;

    localparam logic [7:0] INIT_BYTES [25] = '{
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
        8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
        8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
    };

    logic          clk;
    logic          rst;
    logic          frame_start;
    logic          init_done;
    logic          busy;
    logic          frame_done;
    logic          fb_rd;
    logic [AW-1:0] fb_addr;
    logic [7:0]    fb_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [7:0]    tx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          oled_dc;
    logic          oled_rst_n;

    logic [7:0]    fb_mem [16];
    int            n_vec = 0;
    int            n_err = 0;

    oled_spi_sequencer #(
        .RST_CYCLES  (RST_C),
        .WAKE_CYCLES (WAKE_C),
        .FRAME_BYTES (FB_N),
        .ADDR_W      (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .init_done   (init_done),
        .busy        (busy),
        .frame_done  (frame_done),
        .fb_rd       (fb_rd),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .oled_dc     (oled_dc),
        .oled_rst_n  (oled_rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Framebuffer: data valid only in the cycle right after fb_rd, junk otherwise.
    always @(posedge clk) fb_data <= fb_rd ? fb_mem[fb_addr] : 8'hEE;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rst_n"},  oled_rst_n, 0);
        chk({tag, "_dc"},     oled_dc,    0);
        chk({tag, "_txv"},    tx_valid,   0);
        chk({tag, "_txd"},    tx_data,    0);
        chk({tag, "_fbrd"},   fb_rd,      0);
        chk({tag, "_fbaddr"}, fb_addr,    0);
        chk({tag, "_idone"},  init_done,  0);
        chk({tag, "_busy"},   busy,       1);
        chk({tag, "_fdone"},  frame_done, 0);
        chk({tag, "_rxrdy"},  rx_ready,   1);
    endtask

    // One byte through the SPI master: wait for offer, stall, accept, complete 16 cycles later.
    task automatic xfer(input logic [7:0] exp_d, input logic exp_dc, input int stall, input string tag);
        int n;
        n = 0;
        while (!tx_valid && n < 200) begin
            step();
            n++;
        end
        chk({tag, "_vld"}, tx_valid, 1);
        chk({tag, "_dat"}, tx_data,  exp_d);
        chk({tag, "_dc"},  oled_dc,  exp_dc);
        for (int k = 0; k < stall; k++) begin
            step();
            chk({tag, "_stall_vld"}, tx_valid, 1);
            chk({tag, "_stall_dat"}, {tx_data, oled_dc}, {exp_d, exp_dc});
            chk({tag, "_stall_fbrd"}, fb_rd, 0);
        end
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        chk({tag, "_drop"}, tx_valid, 0);
        repeat (15) step();
        chk({tag, "_hold"}, {tx_data, oled_dc}, {exp_d, exp_dc});
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic run_init(input string tag);
        int n;
        n = 0;
        while (!oled_rst_n && n < 100) begin
            n++;
            step();
            rx_valid = 1'b0;
        end
        chk({tag, "_rst_low_cycles"}, n, RST_C);
        n = 0;
        while (!tx_valid && n < 100) begin
            n++;
            step();
        end
        chk({tag, "_wake_cycles"}, n, WAKE_C + 1);
        for (int i = 0; i < 25; i++) begin
            xfer(INIT_BYTES[i], 1'b0, int'($urandom_range(0, 5)), tag);
            if (i == 3) begin
                frame_start = 1'b1;
                step();
                frame_start = 1'b0;
            end
        end
        chk({tag, "_init_done"}, init_done, 1);
        chk({tag, "_busy"},      busy,      0);
    endtask

    initial begin
        int n;
        rst         = 1'b1;
        frame_start = 1'b0;
        tx_ready    = 1'b0;
        rx_valid    = 1'b0;
        for (int i = 0; i < 16; i++) fb_mem[i] = 8'h00;
        fb_mem[0] = 8'h11;
        fb_mem[1] = 8'h22;
        fb_mem[2] = 8'h33;
        fb_mem[3] = 8'h44;

        repeat (3) step();
        chk_reset("por");
        rst = 1'b0;
        run_init("init");

        repeat (5) step();
        chk("idle_busy", busy,     0);
        chk("idle_txv",  tx_valid, 0);
        chk("idle_fbrd", fb_rd,    0);

        // Frame 1, with a stray request mid-frame.
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        for (int i = 0; i < FB_N; i++) begin
            n = 0;
            while (!fb_rd && n < 50) begin
                step();
                n++;
            end
            chk("f1_rd",   fb_rd,   1);
            chk("f1_addr", fb_addr, i);
            if (i == 1) begin
                frame_start = 1'b1;
                step();
                frame_start = 1'b0;
            end
            xfer(fb_mem[i], 1'b1, int'($urandom_range(0, 5)), "f1");
            if (i < FB_N - 1) chk("f1_no_done", frame_done, 0);
        end
        chk("f1_done",  frame_done, 1);
        chk("f1_busy",  busy,       0);
        chk("f1_idone", init_done,  1);

        // Request coinciding with frame_done must be dropped.
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("f1_done_pulse", frame_done, 0);
        chk("f1_drop_fbrd",  fb_rd,      0);
        repeat (20) step();
        chk("one_frame_busy", busy,     0);
        chk("one_frame_txv",  tx_valid, 0);

        // Frame 2: long stall on byte 0, reset after byte 2 is accepted.
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("f2_rd0",   fb_rd,   1);
        chk("f2_addr0", fb_addr, 0);
        xfer(8'h11, 1'b1, 50, "f2_stall");
        n = 0;
        while (!fb_rd && n < 50) begin
            step();
            n++;
        end
        chk("f2_addr1", fb_addr, 1);
        xfer(8'h22, 1'b1, 0, "f2_b1");
        n = 0;
        while (!tx_valid && n < 50) begin
            step();
            n++;
        end
        chk("f2_b2_dat", tx_data, 8'h33);
        chk("f2_b2_dc",  oled_dc, 1);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        chk_reset("mid");
        rst      = 1'b0;
        rx_valid = 1'b1;
        run_init("reinit");
        chk("reinit_fbaddr", fb_addr,    0);
        chk("reinit_fdone",  frame_done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
